// File: rtl/dac_ctrl_pkg.sv
// Shared widths, profile record and sequencer state encoding for the DAC-controller
// profile sequencer.
package dac_ctrl_pkg;

  localparam int TIME_W  = 48;
  localparam int FREQ_W  = 48;
  localparam int PHASE_W = 14;
  localparam int ACC_W   = 48;
  localparam int PROD_W  = TIME_W + FREQ_W;

  typedef struct packed {
    logic [FREQ_W-1:0]  freq;
    logic [PHASE_W-1:0] phase;
    logic [TIME_W-1:0]  start_time;
  } profile_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_ARMED,
    ST_SWITCH
  } seq_state_t;

endpackage

// File: rtl/profile_fifo.sv
// Small synchronous FIFO of timed profiles with a combinational head view,
// full/empty flags and a synchronous clear.
module profile_fifo
  import dac_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     resetn,
  input  logic     clr,
  input  logic     wr_en,
  input  profile_t wr_data,
  input  logic     rd_en,
  output profile_t rd_data,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  profile_t          mem [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              wr_ok, rd_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_ok = wr_en && !full && !clr;
  assign rd_ok = rd_en && !empty && !clr;
  assign rd_data = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/dds_profile_sequencer.sv
// Timed DDS profile sequencer feeding the phase MAC with phase-continuous switches.
// Optional PROFILE_SEQ_FLUSH_EN adds a flush input that drops queued/pending profiles.
module dds_profile_sequencer
  import dac_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int PHASE_SHIFT = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [TIME_W-1:0]  timestamp,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [FREQ_W-1:0]  s_freq,
  input  logic [PHASE_W-1:0] s_phase,
  input  logic [TIME_W-1:0]  s_time,
`ifdef PROFILE_SEQ_FLUSH_EN
  input  logic               flush,
`endif
  output logic [TIME_W-1:0]  mac_A,
  output logic [FREQ_W-1:0]  mac_B,
  output logic [PHASE_W-1:0] mac_C,
  output logic [TIME_W-1:0]  mac_D,
  output logic [ACC_W-1:0]   mac_E,
  output logic               switch_pulse,
  output logic               late_err,
  output logic               busy
);

  logic flush_w;
`ifdef PROFILE_SEQ_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  seq_state_t         state_q, state_d;
  profile_t           pend_q, pend_d;
  profile_t           head;
  logic [PROD_W-1:0]  mcand_q, mcand_d;
  logic [PROD_W-1:0]  prod_q, prod_d, prod_step;
  logic [FREQ_W-1:0]  mplier_q, mplier_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [ACC_W-1:0]   e_next_q, e_next_d;
  logic [TIME_W-1:0]  a_q, a_d, d_q, delta;
  logic [FREQ_W-1:0]  b_q, b_d;
  logic [PHASE_W-1:0] c_q, c_d;
  logic [ACC_W-1:0]   e_q, e_d;
  logic               pulse_q, pulse_d;
  logic               late_q, late_d;
  logic               ready_q;
  logic               fifo_full, fifo_empty, pop;
  profile_t           wr_prof;

  assign wr_prof = '{freq: s_freq, phase: s_phase, start_time: s_time};
  // ready_q holds s_ready low through reset and for the first edge after release.
  assign s_ready = ready_q && !fifo_full && !flush_w;

  profile_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (flush_w),
    .wr_en   (s_valid && s_ready),
    .wr_data (wr_prof),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign delta     = head.start_time - a_q;
  assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    e_next_d = e_next_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    e_d      = e_q;
    pulse_d  = 1'b0;
    late_d   = late_q;
    pop      = 1'b0;
    if (flush_w) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            pend_d   = head;
            mcand_d  = {{(PROD_W-TIME_W){1'b0}}, delta};
            mplier_d = b_q;
            prod_d   = '0;
            cnt_d    = '0;
            state_d  = ST_CALC;
          end
        end
        ST_CALC: begin
          prod_d   = prod_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 6'd1;
          if (cnt_q == 6'(FREQ_W-1)) begin
            e_next_d = e_q + prod_step[ACC_W-1+PHASE_SHIFT:PHASE_SHIFT];
            // Already past the start time: skip the wait and flag it.
            if (timestamp > pend_q.start_time) begin
              late_d  = 1'b1;
              state_d = ST_SWITCH;
            end else begin
              state_d = ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (timestamp >= pend_q.start_time) state_d = ST_SWITCH;
        end
        ST_SWITCH: begin
          a_d     = pend_q.start_time;
          b_d     = pend_q.freq;
          c_d     = pend_q.phase;
          e_d     = e_next_q;
          pulse_d = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      e_next_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      e_q      <= '0;
      d_q      <= '0;
      pulse_q  <= 1'b0;
      late_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      e_next_q <= e_next_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      e_q      <= e_d;
      d_q      <= timestamp;
      pulse_q  <= pulse_d;
      late_q   <= late_d;
      ready_q  <= 1'b1;
    end
  end

  assign mac_A        = a_q;
  assign mac_B        = b_q;
  assign mac_C        = c_q;
  assign mac_D        = d_q;
  assign mac_E        = e_q;
  assign switch_pulse = pulse_q;
  assign late_err     = late_q;
  assign busy         = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_dds_profile_sequencer.sv
// Self-checking bench for dds_profile_sequencer: directed and random profiles checked
// against an arithmetic phase-accumulation model.
module tb_dds_profile_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [47:0] timestamp = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [47:0] s_freq = '0;
  logic [13:0] s_phase = '0;
  logic [47:0] s_time = '0;
  logic [47:0] mac_A, mac_B, mac_D, mac_E;
  logic [13:0] mac_C;
  logic        switch_pulse, late_err, busy;
`ifdef PROFILE_SEQ_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  longint unsigned cyc = 0;
  logic [47:0] ts_off = '0;

  typedef struct {
    logic [47:0] f;
    logic [13:0] p;
    logic [47:0] t;
    bit          on_time;
  } prof_t;
  prof_t exp_q[$];
  logic [47:0] m_a = '0, m_b = '0, m_e = '0;
  logic [13:0] m_c = '0;

  dds_profile_sequencer #(.FIFO_DEPTH(4), .PHASE_SHIFT(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .timestamp    (timestamp),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_freq       (s_freq),
    .s_phase      (s_phase),
    .s_time       (s_time),
`ifdef PROFILE_SEQ_FLUSH_EN
    .flush        (flush),
`endif
    .mac_A        (mac_A),
    .mac_B        (mac_B),
    .mac_C        (mac_C),
    .mac_D        (mac_D),
    .mac_E        (mac_E),
    .switch_pulse (switch_pulse),
    .late_err     (late_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Free-running system time, advanced on the falling edge; ts_off allows jumps.
  initial forever begin
    @(negedge clk);
    cyc++;
    timestamp = 48'(cyc) + ts_off;
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jump_to(input logic [47:0] target);
    ts_off = ts_off + (target - timestamp);
  endtask

  // Accumulated phase = previous E + ((T - previous A) * previous freq) >> 4, mod 2^48.
  function automatic logic [47:0] model_e(input logic [47:0] t);
    logic [47:0] d;
    logic [95:0] p;
    d = t - m_a;
    p = ({48'd0, d} * {48'd0, m_b}) >> 4;
    return m_e + p[47:0];
  endfunction

  task automatic push(input logic [47:0] f, input logic [13:0] p, input logic [47:0] t,
                      input bit on_time);
    prof_t e;
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_freq  = f;
    s_phase = p;
    s_time  = t;
    while (!s_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $error("FAIL push_timeout: observed s_ready=0 expected s_ready=1 within 3000 cycles");
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    e.f = f; e.p = p; e.t = t; e.on_time = on_time;
    exp_q.push_back(e);
    $display("push   T=%0d freq=%0h phase=%0d at ts=%0d", t, f, p, timestamp);
  endtask

  task automatic expect_switches(input int n);
    prof_t e;
    int w;
    for (int k = 0; k < n; k++) begin
      w = 0;
      do begin
        tick();
        w++;
      end while (!switch_pulse && w < 4000);
      if (!switch_pulse) begin
        total++;
        bad++;
        $error("FAIL switch_timeout: observed no switch_pulse expected one within 4000 cycles");
        return;
      end
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_switch: observed switch_pulse=1 expected no pending profile");
        return;
      end
      e = exp_q.pop_front();
      m_e = model_e(e.t);
      m_a = e.t; m_b = e.f; m_c = e.p;
      chk("mac_A", mac_A, m_a);
      chk("mac_B", mac_B, m_b);
      chk("mac_C", mac_C, m_c);
      chk("mac_E", mac_E, m_e);
      if (e.on_time) chk("switch_time", mac_D, e.t + 48'd1);
      $display("switch T=%0d A=%0d B=%0h C=%0d E=%0h late=%0b", e.t, mac_A, mac_B, mac_C,
               mac_E, late_err);
      tick();
      chk("pulse_one_cycle", switch_pulse, 1'b0);
    end
  endtask

  initial begin
    logic [47:0] t0, tq, tr;
    logic [47:0] rf;
    int pulses;

    // Reset held: everything quiet even though timestamp is moving.
    repeat (3) tick();
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_mac_D", mac_D, 48'd0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("ready_before_edge", s_ready, 1'b0);
    tick();
    chk("ready_after_release", s_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_late", late_err, 1'b0);
    chk("idle_pulse", switch_pulse, 1'b0);
    chk("idle_mac_A", mac_A, 48'd0);
    chk("idle_mac_B", mac_B, 48'd0);
    chk("idle_mac_C", mac_C, 14'd0);
    chk("idle_mac_E", mac_E, 48'd0);
    chk("mac_D_follow", mac_D, timestamp);

    // First profile (E stays 0 since previous freq is 0), then a second one.
    push(48'h1000, 14'd5, 48'd100, 1'b1);
    expect_switches(1);
    push(48'h2000, 14'd0, 48'd200, 1'b1);
    expect_switches(1);
    chk("e_const_check", mac_E, 48'h6400);
    chk("late_still_0", late_err, 1'b0);

    // Fill the queue while the FSM waits in ARMED on a far-off start time.
    t0 = timestamp + 48'd1000;
    push(48'h3, 14'd7, t0, 1'b1);
    repeat (70) tick();
    chk("armed_busy", busy, 1'b1);
    chk("armed_ready", s_ready, 1'b1);
    for (int k = 1; k <= 4; k++)
      push(48'(k * 48'h111), 14'(k), t0 + 48'(100 * k), 1'b1);
    tick();
    chk("full_ready_low", s_ready, 1'b0);
    @(negedge clk);
    s_valid = 1'b1; s_freq = 48'h555; s_phase = 14'd9; s_time = t0 + 48'd500;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("held_write_blocked", s_ready, 1'b0);
    end
    jump_to(t0 - 48'd30);
    fork
      push(48'h555, 14'd9, t0 + 48'd500, 1'b1);
      expect_switches(6);
    join
    chk("fill_queue_drained", busy, 1'b0);

    // Late profile: start time already in the past.
    if (timestamp < 48'd500) jump_to(48'd500);
    push(48'h77, 14'd3, 48'd10, 1'b0);
    expect_switches(1);
    chk("late_set", late_err, 1'b1);
    push(48'h99, 14'd4, timestamp + 48'd200, 1'b1);
    expect_switches(1);
    chk("late_sticky", late_err, 1'b1);

    // Random profiles with random write gaps.
    tr = timestamp + 48'd80;
    fork
      begin
        logic [47:0] tt;
        tt = tr;
        for (int k = 0; k < 6; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          rf = {16'($urandom), $urandom};
          push(rf, 14'($urandom), tt, 1'b1);
          tt = tt + 48'($urandom_range(60, 300));
        end
      end
      expect_switches(6);
    join

`ifdef PROFILE_SEQ_FLUSH_EN
    tq = timestamp + 48'd1000;
    push(48'h12, 14'd1, tq, 1'b1);
    repeat (70) tick();
    push(48'h34, 14'd2, tq + 48'd100, 1'b1);
    @(negedge clk);
    flush = 1'b1;
    s_valid = 1'b1;
    #1;
    chk("flush_ready_low", s_ready, 1'b0);
    tick();
    @(negedge clk);
    flush = 1'b0;
    s_valid = 1'b0;
    #1;
    chk("flush_busy", busy, 1'b0);
    chk("flush_keep_A", mac_A, m_a);
    chk("flush_keep_B", mac_B, m_b);
    chk("flush_keep_C", mac_C, m_c);
    chk("flush_keep_E", mac_E, m_e);
    exp_q.delete();
    jump_to(tq + 48'd500);
    pulses = 0;
    repeat (60) begin
      tick();
      if (switch_pulse) pulses++;
    end
    chk("flush_no_switch", 32'(pulses), 32'd0);
`endif

    // Reset in the middle of CALC with a second profile still queued.
    tq = timestamp + 48'd300;
    push(48'hABC, 14'd11, tq, 1'b1);
    push(48'hDEF, 14'd12, tq + 48'd100, 1'b1);
    repeat (10) tick();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("async_mac_A", mac_A, 48'd0);
    chk("async_mac_B", mac_B, 48'd0);
    chk("async_mac_C", mac_C, 14'd0);
    chk("async_mac_D", mac_D, 48'd0);
    chk("async_mac_E", mac_E, 48'd0);
    chk("async_late", late_err, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_ready", s_ready, 1'b0);
    exp_q.delete();
    m_a = '0; m_b = '0; m_c = '0; m_e = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    jump_to(tq + 48'd500);
    pulses = 0;
    repeat (120) begin
      tick();
      if (switch_pulse) pulses++;
    end
    chk("no_stale_switch", 32'(pulses), 32'd0);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_ready", s_ready, 1'b1);
    chk("post_rst_mac_A", mac_A, 48'd0);
    chk("post_rst_mac_D", mac_D, timestamp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
